sphere_list_traverser: RTL and testbench

Sequences one ray across a table of `NUM_SPHERES` spheres, driving the per-sphere `SphereHit` stage one primitive per cycle and reducing its pipelined `HitData` stream to the single closest hit. It sits directly upstream of `SphereHit`, feeding ray, sphere, color, primitive index and surface type. It also sits downstream of it, consuming `hit_data`. The final result is handed to shading through a valid/ready handshake.

---
 rtl/sphere_list_traverser.sv | 173 +++++++++++++++++
 tb/tb_sphere_list_traverser.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sphere_list_traverser.sv
// sphere_list_traverser
//
// Walks one ray across a table of NUM_SPHERES spheres, presenting one sphere
// per cycle to the downstream SphereHit stage, and reduces the returned hit
// stream to the closest hit. The result is offered with a valid/ready pair.
//
// Optional feature macro: SPHERE_TRAVERSE_EARLY_EXIT_EN
//   When defined, an any-hit query stops issuing as soon as a hit arrives.
//   When undefined, any_hit is captured but has no effect.
//
// Packed record layouts (MSB first):
//   ray      : 6 x 32-bit Fixed (origin xyz, direction xyz)       [191:0]
//   sphere   : 4 x 32-bit Fixed (center xyz, radius)              [127:0]
//   color    : RGB8                                               [23:0]
//   pi       : primitive index, all ones = NULL                   [15:0]
//   st       : surface type, 0 = ST_None                          [1:0]
//   hit data : {bHit[74], T[73:42] signed, PI[41:26], ST[25:24], color[23:0]}
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   start, ray, any_hit traversal request (accepted in IDLE only)
//   busy                high whenever not IDLE
//   sph_idx             sphere table read address
//   sph*                combinational table read data
//   hit_*               operands to SphereHit
//   hit_data            SphereHit result (HIT_LATENCY edges after issue)
//   out_valid/out_ready/out_hit  closest-hit result handshake
//
// States:
//   IDLE   | waiting for start
//   ISSUE  | presenting one sphere per cycle
//   DRAIN  | waiting for in-flight results to come back
//   OUTPUT | result held on out_hit until out_ready

module sphere_list_traverser #(
    parameter int NUM_SPHERES = 8,
    parameter int HIT_LATENCY = 1,
    localparam int IDX_W      = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1,
    localparam int FIXED_W    = 32,
    localparam int RAY_W      = 6 * FIXED_W,
    localparam int SPHERE_W   = 4 * FIXED_W,
    localparam int RGB_W      = 24,
    localparam int PI_W       = 16,
    localparam int ST_W       = 2,
    localparam int HIT_W      = 1 + FIXED_W + PI_W + ST_W + RGB_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [RAY_W-1:0]    ray,
    input  logic                any_hit,
    output logic                busy,
    output logic [IDX_W-1:0]    sph_idx,
    input  logic [SPHERE_W-1:0] sph,
    input  logic [RGB_W-1:0]    sph_color,
    input  logic [PI_W-1:0]     sph_pi,
    input  logic [ST_W-1:0]     sph_st,
    output logic [RAY_W-1:0]    hit_ray,
    output logic [SPHERE_W-1:0] hit_sphere,
    output logic [RGB_W-1:0]    hit_color,
    output logic [PI_W-1:0]     hit_pi,
    output logic [ST_W-1:0]     hit_st,
    input  logic [HIT_W-1:0]    hit_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [HIT_W-1:0]    out_hit
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

    localparam logic [PI_W-1:0]    NULL_PI   = '1;
    localparam logic [FIXED_W-1:0] FIXED_MAX = {1'b0, {(FIXED_W-1){1'b1}}};
    localparam logic [HIT_W-1:0]   BEST_INIT = {1'b0, FIXED_MAX, NULL_PI, {ST_W{1'b0}}, {RGB_W{1'b0}}};

    state_t                 state, state_nx;
    logic [RAY_W-1:0]       ray_q;
    logic                   any_hit_q;
    logic [IDX_W-1:0]       cnt;
    logic [HIT_LATENCY-1:0] inflight;
    logic [HIT_W-1:0]       best;
    logic [HIT_W-1:0]       out_hit_q;

    logic                   push;
    logic                   cand_valid;
    logic                   cand_hit;
    logic signed [FIXED_W-1:0] cand_t;
    logic                   best_hit;
    logic signed [FIXED_W-1:0] best_t;
    logic                   take;
    logic                   last_idx;
    logic                   early_exit;

    assign cand_valid = inflight[HIT_LATENCY-1];
    assign cand_hit   = hit_data[HIT_W-1];
    assign cand_t     = hit_data[HIT_W-2 -: FIXED_W];
    assign best_hit   = best[HIT_W-1];
    assign best_t     = best[HIT_W-2 -: FIXED_W];

    // Strict less-than so that an equal T keeps the earlier (lower index) hit.
    assign take     = cand_valid && cand_hit && (!best_hit || (cand_t < best_t));
    assign last_idx = (cnt == IDX_W'(NUM_SPHERES - 1));

`ifdef SPHERE_TRAVERSE_EARLY_EXIT_EN
    assign early_exit = any_hit_q && cand_valid && cand_hit;
`else
    // any_hit is still captured so the port behaves identically; it never
    // affects sequencing in this build.
    assign early_exit = any_hit_q & 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (last_idx || early_exit) state_nx = DRAIN;
            DRAIN:   if (inflight == '0) state_nx = OUTPUT;
            OUTPUT:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The in-flight bit is loaded on the edge that begins a sphere's
    // presentation cycle, so it reaches the last stage exactly when that
    // sphere's hit_data is sampled HIT_LATENCY edges later.
    assign push = (state_nx == ISSUE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            ray_q     <= '0;
            any_hit_q <= 1'b0;
            cnt       <= '0;
            inflight  <= '0;
            best      <= BEST_INIT;
            out_hit_q <= BEST_INIT;
        end else begin
            state       <= state_nx;
            inflight[0] <= push;
            for (int i = 1; i < HIT_LATENCY; i++) begin
                inflight[i] <= inflight[i-1];
            end

            if (state == IDLE && start) begin
                ray_q     <= ray;
                any_hit_q <= any_hit;
                cnt       <= '0;
                best      <= BEST_INIT;
            end else begin
                if (take) begin
                    best <= hit_data;
                end
                if (state == ISSUE) begin
                    cnt <= cnt + IDX_W'(1);
                end
            end

            if (state == DRAIN && state_nx == OUTPUT) begin
                out_hit_q <= best;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign sph_idx    = cnt;
    assign hit_ray    = ray_q;
    assign hit_sphere = sph;
    assign hit_color  = sph_color;
    assign hit_st     = sph_st;
    assign hit_pi     = (state == ISSUE) ? sph_pi : NULL_PI;
    assign out_valid  = (state == OUTPUT);
    assign out_hit    = out_hit_q;

endmodule

// File: tb/tb_sphere_list_traverser.sv
// Testbench for sphere_list_traverser (NUM_SPHERES=8, HIT_LATENCY=1).
// A stand-in SphereHit derives bHit from sphere bit 96 and T from sphere
// bits [31:0]; with a latency of one edge its output is combinational on
// the presented operands.

module tb_sphere_list_traverser;

    localparam int N = 8;
    localparam int L = 1;
    localparam logic [15:0] NULL_PI = 16'hFFFF;
    localparam logic [74:0] INIT    = {1'b0, 32'h7FFF_FFFF, 16'hFFFF, 2'b00, 24'h0};

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [191:0] ray;
    logic         any_hit;
    logic         busy;
    logic [2:0]   sph_idx;
    logic [127:0] sph;
    logic [23:0]  sph_color;
    logic [15:0]  sph_pi;
    logic [1:0]   sph_st;
    logic [191:0] hit_ray;
    logic [127:0] hit_sphere;
    logic [23:0]  hit_color;
    logic [15:0]  hit_pi;
    logic [1:0]   hit_st;
    logic [74:0]  hit_data;
    logic         out_valid;
    logic         out_ready;
    logic [74:0]  out_hit;

    logic [127:0] tab_sph [N];
    logic [23:0]  tab_col [N];
    logic [1:0]   tab_st  [N];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sphere_list_traverser #(.NUM_SPHERES(N), .HIT_LATENCY(L)) dut (
        .clk(clk), .resetn(resetn), .start(start), .ray(ray), .any_hit(any_hit),
        .busy(busy), .sph_idx(sph_idx), .sph(sph), .sph_color(sph_color),
        .sph_pi(sph_pi), .sph_st(sph_st), .hit_ray(hit_ray), .hit_sphere(hit_sphere),
        .hit_color(hit_color), .hit_pi(hit_pi), .hit_st(hit_st), .hit_data(hit_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit)
    );

    assign sph       = tab_sph[sph_idx];
    assign sph_color = tab_col[sph_idx];
    assign sph_st    = tab_st[sph_idx];
    assign sph_pi    = {13'b0, sph_idx};
    assign hit_data  = {hit_sphere[96], hit_sphere[31:0], hit_pi, hit_st, hit_color};

    task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_entry(input int i, input bit hit, input logic [31:0] t);
        tab_sph[i] = {$urandom, $urandom, $urandom, $urandom};
        tab_sph[i][96] = hit;
        tab_sph[i][31:0] = t;
        tab_col[i] = 24'($urandom);
        tab_st[i]  = 2'($urandom);
    endtask

    task automatic clear_table();
        for (int i = 0; i < N; i++) set_entry(i, 1'b0, $urandom);
    endtask

    // Reference: spheres issued in order, closest signed T wins, first one wins ties.
    function automatic void model(input bit ah, output int nis, output logic [74:0] exp);
        int first_hit;
        first_hit = -1;
        nis = N;
        for (int i = 0; i < N; i++)
            if (first_hit < 0 && tab_sph[i][96]) first_hit = i;
`ifdef SPHERE_TRAVERSE_EARLY_EXIT_EN
        if (ah && first_hit >= 0 && first_hit + L < N) nis = first_hit + L;
`endif
        exp = INIT;
        for (int i = 0; i < nis; i++) begin
            if (tab_sph[i][96] &&
                (!exp[74] || $signed(tab_sph[i][31:0]) < $signed(exp[73:42])))
                exp = {1'b1, tab_sph[i][31:0], 16'(i), tab_st[i], tab_col[i]};
        end
    endfunction

    task automatic run_ray(input bit ah, input int hold, input bit pulses);
        int nis;
        int c;
        int nseen;
        bit order_ok;
        bit ray_ok;
        logic [74:0]  exp;
        logic [191:0] r;
        model(ah, nis, exp);
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        order_ok = 1'b1;
        ray_ok = 1'b1;
        nseen = 0;
        @(negedge clk);
        start = 1'b1; ray = r; any_hit = ah;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) ray[i*32 +: 32] = $urandom;
        any_hit = ~ah;
        chk_val("busy_run", 128'(busy), 128'(1));
        c = 1;
        while (1) begin
            if (hit_pi != NULL_PI) begin
                if (hit_pi != 16'(nseen)) order_ok = 1'b0;
                if (hit_ray !== r) ray_ok = 1'b0;
                nseen++;
            end
            if (out_valid || c >= 60) break;
            @(negedge clk);
            c++;
        end
        chk_val("latency", 128'(c), 128'(nis + L + 1));
        chk_val("issued", 128'(nseen), 128'(nis));
        chk_val("issue_order", 128'(order_ok), 128'(1));
        chk_val("ray_passthru", 128'(ray_ok), 128'(1));
        chk_val("out_hit", 128'(out_hit), 128'(exp));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start = pulses & h[0];
            @(negedge clk);
            chk_val("hold_valid", 128'(out_valid), 128'(1));
            chk_val("hold_stable", 128'(out_hit), 128'(exp));
        end
        start = pulses;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        chk_val("idle_busy", 128'(busy), 128'(0));
        chk_val("idle_valid", 128'(out_valid), 128'(0));
        chk_val("idle_pi", 128'(hit_pi), 128'(NULL_PI));
    endtask

    task automatic reset_mid();
        int c;
        @(negedge clk);
        start = 1'b1; any_hit = 1'b0;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (hit_pi != 16'd4 && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk_val("reached_idx4", 128'(hit_pi), 128'(4));
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk_val("rst_busy", 128'(busy), 128'(0));
        chk_val("rst_valid", 128'(out_valid), 128'(0));
        chk_val("rst_pi", 128'(hit_pi), 128'(NULL_PI));
        chk_val("rst_out_hit", 128'(out_hit), 128'(INIT));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; ray = '0; any_hit = 1'b0; out_ready = 1'b0;
        clear_table();
        repeat (3) @(negedge clk);
        chk_val("reset_busy", 128'(busy), 128'(0));
        chk_val("reset_valid", 128'(out_valid), 128'(0));
        chk_val("reset_pi", 128'(hit_pi), 128'(NULL_PI));
        chk_val("reset_out_hit", 128'(out_hit), 128'(INIT));
        resetn = 1'b1;

        // no hits anywhere
        clear_table();
        run_ray(1'b0, 0, 1'b0);
        chk_val("nohit_bhit", 128'(out_hit[74]), 128'(0));
        chk_val("nohit_pi", 128'(out_hit[41:26]), 128'(NULL_PI));
        chk_val("nohit_st", 128'(out_hit[25:24]), 128'(0));

        // closer hit later in the list wins
        clear_table();
        set_entry(2, 1'b1, 32'h0005_0000);
        set_entry(6, 1'b1, 32'h0001_8000);
        run_ray(1'b0, 0, 1'b0);
        chk_val("closest_pi", 128'(out_hit[41:26]), 128'(6));
        chk_val("closest_t", 128'(out_hit[73:42]), 128'(32'h0001_8000));
        chk_val("closest_col", 128'(out_hit[23:0]), 128'(tab_col[6]));

        // equal T keeps the earlier index
        clear_table();
        set_entry(3, 1'b1, 32'h0);
        set_entry(5, 1'b1, 32'h0);
        run_ray(1'b0, 0, 1'b0);
        chk_val("tie_pi", 128'(out_hit[41:26]), 128'(3));

        // back-pressure with ignored start pulses
        clear_table();
        set_entry(4, 1'b1, 32'hFFFF_0000);
        run_ray(1'b0, 4, 1'b1);

        // reset in the middle, then a clean traversal
        clear_table();
        set_entry(1, 1'b1, 32'h0002_0000);
        reset_mid();
        run_ray(1'b0, 0, 1'b0);
        chk_val("after_rst_pi", 128'(out_hit[41:26]), 128'(1));

        // any-hit query: early exit only when the feature is built in
        clear_table();
        set_entry(1, 1'b1, 32'h0009_0000);
        set_entry(5, 1'b1, 32'h0001_0000);
        run_ray(1'b1, 0, 1'b0);
`ifdef SPHERE_TRAVERSE_EARLY_EXIT_EN
        chk_val("anyhit_pi", 128'(out_hit[41:26]), 128'(1));
`else
        chk_val("anyhit_pi", 128'(out_hit[41:26]), 128'(5));
`endif

        // randomized traversals
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 0)
                    set_entry(i, ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 3)));
                else
                    set_entry(i, ($urandom_range(0, 3) == 0), $urandom);
            end
            run_ray(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
